// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester/response channels and the shared-ALU drive lines.
// The arbiter uses the slave view; requesters and the external ALU use the master view.
interface alu_arbiter_if;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [4:0]  req0_conf,  req1_conf;
   logic        req0_sign,  req1_sign;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready, rsp1_ready;
   logic [31:0] rsp0_result, rsp1_result;
   logic        rsp0_zero, rsp1_zero;
   logic        rsp0_err,  rsp1_err;
   logic [4:0]  alu_conf;
   logic        alu_sign;
   logic [31:0] alu_in1, alu_in2;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        busy;

   modport slave (
      input  req0_valid, req1_valid, req0_conf, req1_conf, req0_sign, req1_sign,
             req0_a, req0_b, req1_a, req1_b, rsp0_ready, rsp1_ready,
             alu_result, alu_zero,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
             rsp0_result, rsp1_result, rsp0_zero, rsp1_zero, rsp0_err, rsp1_err,
             alu_conf, alu_sign, alu_in1, alu_in2, busy
   );

   modport master (
      output req0_valid, req1_valid, req0_conf, req1_conf, req0_sign, req1_sign,
             req0_a, req0_b, req1_a, req1_b, rsp0_ready, rsp1_ready,
             alu_result, alu_zero,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
             rsp0_result, rsp1_result, rsp0_zero, rsp1_zero, rsp0_err, rsp1_err,
             alu_conf, alu_sign, alu_in1, alu_in2, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU: one operation in
// flight at a time (IDLE -> EXEC -> RESP), round-robin or fixed-priority grant.
module alu_arbiter #(
   parameter int RR_EN = 1
) (
   input  logic         clk,
   input  logic         reset,
   alu_arbiter_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_EXEC = 2'b01;
   localparam logic [1:0] ST_RESP = 2'b10;

   logic [1:0]  state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_q,  last_d;
   logic [4:0]  conf_q,  conf_d;
   logic        sign_q,  sign_d;
   logic [31:0] in1_q,   in1_d;
   logic [31:0] in2_q,   in2_d;
   logic [31:0] res0_q,  res0_d, res1_q, res1_d;
   logic        zero0_q, zero0_d, zero1_q, zero1_d;
   logic        err0_q,  err0_d,  err1_q,  err1_d;
   logic        grant, idle, accept, owner_rdy;

   function automatic logic conf_legal(input logic [4:0] c);
      case (c)
         5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00110, 5'b00111,
         5'b01100, 5'b01101, 5'b10000, 5'b11000, 5'b11001: conf_legal = 1'b1;
         default:                                          conf_legal = 1'b0;
      endcase
   endfunction

   // Ready is gated by reset so nothing is offered while the block is held in reset.
   assign idle = reset && (state_q == ST_IDLE);

   always_comb begin
      grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid) grant = (RR_EN != 0) ? ~last_q : 1'b0;
      else if (bus.req1_valid)              grant = 1'b1;
   end

   assign accept         = idle && (bus.req0_valid || bus.req1_valid);
   assign bus.req0_ready = idle && !grant && bus.req0_valid;
   assign bus.req1_ready = idle &&  grant && bus.req1_valid;
   assign owner_rdy      = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      conf_d  = conf_q;
      sign_d  = sign_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      res0_d  = res0_q;
      res1_d  = res1_q;
      zero0_d = zero0_q;
      zero1_d = zero1_q;
      err0_d  = err0_q;
      err1_d  = err1_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_EXEC;
               owner_d = grant;
               last_d  = grant;
               conf_d  = grant ? bus.req1_conf : bus.req0_conf;
               sign_d  = grant ? bus.req1_sign : bus.req0_sign;
               in1_d   = grant ? bus.req1_a    : bus.req0_a;
               in2_d   = grant ? bus.req1_b    : bus.req0_b;
            end
         end
         ST_EXEC: begin
            // Illegal codes still capture the ALU output; only the error flag differs.
            state_d = ST_RESP;
            if (owner_q) begin
               res1_d  = bus.alu_result;
               zero1_d = bus.alu_zero;
               err1_d  = !conf_legal(conf_q);
            end else begin
               res0_d  = bus.alu_result;
               zero0_d = bus.alu_zero;
               err0_d  = !conf_legal(conf_q);
            end
         end
         ST_RESP: begin
            if (owner_rdy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         conf_q  <= 5'b00000;
         sign_q  <= 1'b0;
         in1_q   <= 32'd0;
         in2_q   <= 32'd0;
         res0_q  <= 32'd0;
         res1_q  <= 32'd0;
         zero0_q <= 1'b0;
         zero1_q <= 1'b0;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         conf_q  <= conf_d;
         sign_q  <= sign_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         res0_q  <= res0_d;
         res1_q  <= res1_d;
         zero0_q <= zero0_d;
         zero1_q <= zero1_d;
         err0_q  <= err0_d;
         err1_q  <= err1_d;
      end
   end

   assign bus.rsp0_valid  = (state_q == ST_RESP) && !owner_q;
   assign bus.rsp1_valid  = (state_q == ST_RESP) &&  owner_q;
   assign bus.rsp0_result = res0_q;
   assign bus.rsp1_result = res1_q;
   assign bus.rsp0_zero   = zero0_q;
   assign bus.rsp1_zero   = zero1_q;
   assign bus.rsp0_err    = err0_q;
   assign bus.rsp1_err    = err1_q;
   assign bus.alu_conf    = conf_q;
   assign bus.alu_sign    = sign_q;
   assign bus.alu_in1     = in1_q;
   assign bus.alu_in2     = in2_q;
   assign bus.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance, each with a
// bench-side ALU, checked every cycle against a transaction-level model plus literals.
module tb_alu_arbiter;
   localparam logic [4:0] OP_ADD = 5'b00000;
   localparam logic [4:0] OP_SUB = 5'b00001;
   localparam logic [4:0] OP_AND = 5'b00010;
   localparam logic [4:0] OP_OR  = 5'b00011;
   localparam logic [4:0] OP_BAD = 5'b00101;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // index [i]: 0 = round-robin instance, 1 = fixed-priority instance; [n] = requester
   logic [1:0]  s_valid [2];
   logic [4:0]  s_conf  [2][2];
   logic [1:0]  s_sign  [2];
   logic [31:0] s_a     [2][2];
   logic [31:0] s_b     [2][2];
   logic [1:0]  s_rready[2];

   logic [1:0]  o_ready [2];
   logic [1:0]  o_rvalid[2];
   logic [1:0]  o_zero  [2];
   logic [1:0]  o_err   [2];
   logic [31:0] o_res   [2][2];
   logic [4:0]  o_conf  [2];
   logic        o_sign  [2];
   logic [31:0] o_in1   [2];
   logic [31:0] o_in2   [2];
   logic        o_busy  [2];

   function automatic logic [31:0] alu_fn(input logic [4:0] c, input logic sg,
                                          input logic [31:0] a, input logic [31:0] b);
      case (c)
         5'b00000: alu_fn = a + b;
         5'b00001: alu_fn = a - b;
         5'b00010: alu_fn = a & b;
         5'b00011: alu_fn = a | b;
         5'b00110: alu_fn = a ^ b;
         5'b00111: alu_fn = sg ? {31'd0, $signed(a) < $signed(b)} : {31'd0, a < b};
         5'b01100: alu_fn = a << b[4:0];
         5'b01101: alu_fn = a >> b[4:0];
         5'b10000: alu_fn = $signed(a) >>> b[4:0];
         5'b11000: alu_fn = {31'd0, a == b};
         5'b11001: alu_fn = {31'd0, a != b};
         default:  alu_fn = 32'd0;
      endcase
   endfunction

   function automatic bit legal(input logic [4:0] c);
      return c inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd7, 5'd12, 5'd13, 5'd16, 5'd24, 5'd25};
   endfunction

   alu_arbiter_if bus_rr();
   alu_arbiter_if bus_fp();

   alu_arbiter #(.RR_EN(1)) dut_rr (.clk(clk), .reset(reset), .bus(bus_rr));
   alu_arbiter #(.RR_EN(0)) dut_fp (.clk(clk), .reset(reset), .bus(bus_fp));

   assign bus_rr.req0_valid = s_valid[0][0];  assign bus_rr.req1_valid = s_valid[0][1];
   assign bus_rr.req0_conf  = s_conf[0][0];   assign bus_rr.req1_conf  = s_conf[0][1];
   assign bus_rr.req0_sign  = s_sign[0][0];   assign bus_rr.req1_sign  = s_sign[0][1];
   assign bus_rr.req0_a     = s_a[0][0];      assign bus_rr.req1_a     = s_a[0][1];
   assign bus_rr.req0_b     = s_b[0][0];      assign bus_rr.req1_b     = s_b[0][1];
   assign bus_rr.rsp0_ready = s_rready[0][0]; assign bus_rr.rsp1_ready = s_rready[0][1];
   assign bus_rr.alu_result = alu_fn(bus_rr.alu_conf, bus_rr.alu_sign, bus_rr.alu_in1, bus_rr.alu_in2);
   assign bus_rr.alu_zero   = (bus_rr.alu_result == 32'd0);

   assign bus_fp.req0_valid = s_valid[1][0];  assign bus_fp.req1_valid = s_valid[1][1];
   assign bus_fp.req0_conf  = s_conf[1][0];   assign bus_fp.req1_conf  = s_conf[1][1];
   assign bus_fp.req0_sign  = s_sign[1][0];   assign bus_fp.req1_sign  = s_sign[1][1];
   assign bus_fp.req0_a     = s_a[1][0];      assign bus_fp.req1_a     = s_a[1][1];
   assign bus_fp.req0_b     = s_b[1][0];      assign bus_fp.req1_b     = s_b[1][1];
   assign bus_fp.rsp0_ready = s_rready[1][0]; assign bus_fp.rsp1_ready = s_rready[1][1];
   assign bus_fp.alu_result = alu_fn(bus_fp.alu_conf, bus_fp.alu_sign, bus_fp.alu_in1, bus_fp.alu_in2);
   assign bus_fp.alu_zero   = (bus_fp.alu_result == 32'd0);

   assign o_ready[0]  = {bus_rr.req1_ready, bus_rr.req0_ready};
   assign o_rvalid[0] = {bus_rr.rsp1_valid, bus_rr.rsp0_valid};
   assign o_zero[0]   = {bus_rr.rsp1_zero,  bus_rr.rsp0_zero};
   assign o_err[0]    = {bus_rr.rsp1_err,   bus_rr.rsp0_err};
   assign o_res[0][0] = bus_rr.rsp0_result;
   assign o_res[0][1] = bus_rr.rsp1_result;
   assign o_conf[0]   = bus_rr.alu_conf;
   assign o_sign[0]   = bus_rr.alu_sign;
   assign o_in1[0]    = bus_rr.alu_in1;
   assign o_in2[0]    = bus_rr.alu_in2;
   assign o_busy[0]   = bus_rr.busy;

   assign o_ready[1]  = {bus_fp.req1_ready, bus_fp.req0_ready};
   assign o_rvalid[1] = {bus_fp.rsp1_valid, bus_fp.rsp0_valid};
   assign o_zero[1]   = {bus_fp.rsp1_zero,  bus_fp.rsp0_zero};
   assign o_err[1]    = {bus_fp.rsp1_err,   bus_fp.rsp0_err};
   assign o_res[1][0] = bus_fp.rsp0_result;
   assign o_res[1][1] = bus_fp.rsp1_result;
   assign o_conf[1]   = bus_fp.alu_conf;
   assign o_sign[1]   = bus_fp.alu_sign;
   assign o_in1[1]    = bus_fp.alu_in1;
   assign o_in2[1]    = bus_fp.alu_in2;
   assign o_busy[1]   = bus_fp.busy;

   // Model: at most one operation in flight per instance; age 0 = being computed,
   // age 1 = result on offer until its owner takes it.
   bit          m_pend [2];
   int          m_age  [2];
   bit          m_own  [2];
   bit          m_last [2];
   logic [4:0]  m_conf [2];
   logic        m_sign [2];
   logic [31:0] m_a    [2];
   logic [31:0] m_b    [2];
   logic [31:0] m_res  [2][2];
   bit          m_zero [2][2];
   bit          m_err  [2][2];

   function automatic bit exp_grant_to(input int i, input int n);
      if (!reset || m_pend[i] || !s_valid[i][n]) return 1'b0;
      if (!s_valid[i][1-n]) return 1'b1;
      if (i == 1) return (n == 0);
      return (n != int'(m_last[i]));
   endfunction

   always @(posedge clk or negedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            m_pend[i] <= 1'b0;  m_age[i] <= 0;  m_own[i] <= 1'b0;  m_last[i] <= 1'b1;
            m_conf[i] <= 5'd0;  m_sign[i] <= 1'b0;  m_a[i] <= 32'd0;  m_b[i] <= 32'd0;
            for (int n = 0; n < 2; n++) begin
               m_res[i][n] <= 32'd0;  m_zero[i][n] <= 1'b0;  m_err[i][n] <= 1'b0;
            end
         end else if (!m_pend[i]) begin
            for (int n = 0; n < 2; n++) begin
               if (exp_grant_to(i, n)) begin
                  m_pend[i] <= 1'b1;  m_age[i] <= 0;  m_own[i] <= n[0];  m_last[i] <= n[0];
                  m_conf[i] <= s_conf[i][n];  m_sign[i] <= s_sign[i][n];
                  m_a[i] <= s_a[i][n];  m_b[i] <= s_b[i][n];
               end
            end
         end else if (m_age[i] == 0) begin
            m_res[i][m_own[i]]  <= alu_fn(m_conf[i], m_sign[i], m_a[i], m_b[i]);
            m_zero[i][m_own[i]] <= (alu_fn(m_conf[i], m_sign[i], m_a[i], m_b[i]) == 32'd0);
            m_err[i][m_own[i]]  <= !legal(m_conf[i]);
            m_age[i] <= 1;
         end else if (s_rready[i][m_own[i]]) begin
            m_pend[i] <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         for (int n = 0; n < 2; n++) begin
            chk($sformatf("ready%0d_i%0d", n, i), o_ready[i][n], exp_grant_to(i, n));
            chk($sformatf("rvalid%0d_i%0d", n, i), o_rvalid[i][n],
                m_pend[i] && m_age[i] >= 1 && int'(m_own[i]) == n);
            chk($sformatf("result%0d_i%0d", n, i), o_res[i][n], m_res[i][n]);
            chk($sformatf("zero%0d_i%0d", n, i), o_zero[i][n], m_zero[i][n]);
            chk($sformatf("err%0d_i%0d", n, i), o_err[i][n], m_err[i][n]);
         end
         chk($sformatf("busy_i%0d", i), o_busy[i], m_pend[i]);
         chk($sformatf("alu_conf_i%0d", i), o_conf[i], m_conf[i]);
         chk($sformatf("alu_sign_i%0d", i), o_sign[i], m_sign[i]);
         chk($sformatf("alu_in1_i%0d", i), o_in1[i], m_a[i]);
         chk($sformatf("alu_in2_i%0d", i), o_in2[i], m_b[i]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int i, input int n, input logic [4:0] c, input logic sg,
                          input logic [31:0] a, input logic [31:0] b);
      s_valid[i][n] = 1'b1;
      s_conf[i][n]  = c;
      s_sign[i][n]  = sg;
      s_a[i][n]     = a;
      s_b[i][n]     = b;
   endtask

   task automatic wait_grant(input int i, input int n);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (o_ready[i][n]) begin
            ok = 1'b1;
            break;
         end
      end
      chk($sformatf("grant_wait_i%0d_r%0d", i, n), ok, 1);
   endtask

   task automatic issue(input int i, input int n, input logic [4:0] c, input logic sg,
                        input logic [31:0] a, input logic [31:0] b);
      set_req(i, n, c, sg, a, b);
      wait_grant(i, n);
      tick();
      s_valid[i][n] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (!o_busy[i]) begin
            ok = 1'b1;
            break;
         end
      end
      chk($sformatf("idle_wait_i%0d", i), ok, 1);
      tick();
   endtask

   int gseq [3];
   int cnt0, cnt1;

   initial begin
      for (int i = 0; i < 2; i++) begin
         s_valid[i] = 2'b00;  s_sign[i] = 2'b00;  s_rready[i] = 2'b11;
         for (int n = 0; n < 2; n++) begin
            s_conf[i][n] = 5'd0;  s_a[i][n] = 32'd0;  s_b[i][n] = 32'd0;
         end
      end
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", o_busy[0], 0);
      chk("rst_in1", o_in1[1], 0);
      chk("rst_rvalid", o_rvalid[0], 0);

      // Request present at release is taken on the first edge; ADD 5+7.
      tick();
      reset = 1'b1;
      set_req(1, 0, OP_ADD, 1'b0, 32'd5, 32'd7);
      @(negedge clk);
      chk("t1_ready_first_cycle", o_ready[1][0], 1);
      tick();
      s_valid[1][0] = 1'b0;
      @(negedge clk);
      chk("t1_alu_in1", o_in1[1], 32'd5);
      chk("t1_alu_in2", o_in2[1], 32'd7);
      chk("t1_rvalid_early", o_rvalid[1][0], 0);
      @(negedge clk);
      chk("t1_rvalid", o_rvalid[1][0], 1);
      chk("t1_result", o_res[1][0], 32'd12);
      chk("t1_zero", o_zero[1][0], 0);
      chk("t1_err", o_err[1][0], 0);
      wait_idle(1);

      // Round-robin with both requesters valid throughout.
      set_req(0, 0, OP_SUB, 1'b0, 32'd9, 32'd9);
      set_req(0, 1, OP_OR, 1'b0, 32'h0000_00F0, 32'h0000_000F);
      for (int k = 0; k < 3; k++) begin
         gseq[k] = -1;
         for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (o_ready[0] != 2'b00) begin
               gseq[k] = o_ready[0][1] ? 1 : 0;
               break;
            end
         end
         tick();
      end
      s_valid[0] = 2'b00;
      chk("rr_grant0", gseq[0], 0);
      chk("rr_grant1", gseq[1], 1);
      chk("rr_grant2", gseq[2], 0);
      wait_idle(0);
      chk("rr_sub_result", o_res[0][0], 32'd0);
      chk("rr_sub_zero", o_zero[0][0], 1);
      chk("rr_or_result", o_res[0][1], 32'h0000_00FF);
      chk("rr_or_zero", o_zero[0][1], 0);

      // Fixed priority: requester 1 starves while requester 0 stays valid.
      set_req(1, 0, OP_AND, 1'b0, 32'h0000_FF00, 32'h0000_0FF0);
      set_req(1, 1, OP_ADD, 1'b0, 32'd1, 32'd2);
      cnt0 = 0;
      cnt1 = 0;
      repeat (12) begin
         @(negedge clk);
         if (o_ready[1][0]) cnt0++;
         if (o_ready[1][1]) cnt1++;
      end
      chk("fp_req0_grants", cnt0, 4);
      chk("fp_req1_starved", cnt1, 0);
      tick();
      s_valid[1][0] = 1'b0;
      wait_grant(1, 1);
      tick();
      s_valid[1][1] = 1'b0;
      wait_idle(1);
      chk("fp_req1_result", o_res[1][1], 32'd3);

      // Illegal operation code.
      issue(0, 1, OP_BAD, 1'b0, 32'd3, 32'd4);
      @(negedge clk);
      @(negedge clk);
      chk("bad_rvalid", o_rvalid[0][1], 1);
      chk("bad_err", o_err[0][1], 1);
      chk("bad_result", o_res[0][1], 32'd0);
      chk("bad_zero", o_zero[0][1], 1);
      wait_idle(0);

      // Response backpressure holds the block in RESP.
      s_rready[0][0] = 1'b0;
      issue(0, 0, OP_ADD, 1'b0, 32'd100, 32'd23);
      set_req(0, 1, OP_ADD, 1'b0, 32'd1, 32'd1);
      @(negedge clk);
      repeat (10) begin
         @(negedge clk);
         chk("bp_rvalid", o_rvalid[0][0], 1);
         chk("bp_result", o_res[0][0], 32'd123);
         chk("bp_req1_ready", o_ready[0][1], 0);
      end
      tick();
      s_rready[0][0] = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("bp_release_busy", o_busy[0], 0);
      chk("bp_release_req1_ready", o_ready[0][1], 1);
      tick();
      s_valid[0][1] = 1'b0;
      wait_idle(0);
      chk("bp_req1_result", o_res[0][1], 32'd2);

      // Reset pulse while a response is pending.
      s_rready[0][1] = 1'b0;
      issue(0, 1, OP_ADD, 1'b0, 32'd7, 32'd8);
      @(negedge clk);
      @(negedge clk);
      chk("rs_rvalid_before", o_rvalid[0][1], 1);
      chk("rs_result_before", o_res[0][1], 32'd15);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("rs_async_rvalid", o_rvalid[0][1], 0);
      chk("rs_async_busy", o_busy[0], 0);
      chk("rs_async_result", o_res[0][1], 32'd0);
      chk("rs_async_in1", o_in1[0], 32'd0);
      chk("rs_async_conf", o_conf[0], 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      s_rready[0][1] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rs_no_stale_rvalid", o_rvalid[0][1], 0);
         chk("rs_no_stale_busy", o_busy[0], 0);
      end
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
